// File: rtl/ex_mdu_stage_pkg.sv
// Shared encodings for the execute stage: ALU class/op codes, MDU FSM states
// and the multiply/divide op selector.
package ex_mdu_stage_pkg;

  localparam int ALUSEL_W = 3;
  localparam int ALUOP_W  = 8;

  // Op classes
  localparam logic [ALUSEL_W-1:0] ALUSEL_NOP    = 3'd0;
  localparam logic [ALUSEL_W-1:0] ALUSEL_LOGIC  = 3'd1;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SHIFT  = 3'd2;
  localparam logic [ALUSEL_W-1:0] ALUSEL_ARITH  = 3'd3;
  localparam logic [ALUSEL_W-1:0] ALUSEL_MOVE   = 3'd4;
  localparam logic [ALUSEL_W-1:0] ALUSEL_MULDIV = 3'd5;

  // Operation codes within the classes
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] ALUOP_XOR   = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] ALUOP_NOR   = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] ALUOP_ANDI  = 8'b0101_1001;
  localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 8'b0101_1010;
  localparam logic [ALUOP_W-1:0] ALUOP_XORI  = 8'b0101_1011;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 8'b0101_1100;
  localparam logic [ALUOP_W-1:0] ALUOP_SLL   = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] ALUOP_SRL   = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] ALUOP_SRA   = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 8'b0010_0000;
  localparam logic [ALUOP_W-1:0] ALUOP_ADDU  = 8'b0010_0001;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 8'b0010_0010;
  localparam logic [ALUOP_W-1:0] ALUOP_SUBU  = 8'b0010_0011;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 8'b0010_1010;
  localparam logic [ALUOP_W-1:0] ALUOP_SLTU  = 8'b0010_1011;
  localparam logic [ALUOP_W-1:0] ALUOP_MFHI  = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] ALUOP_MTHI  = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] ALUOP_MFLO  = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] ALUOP_MTLO  = 8'b0001_0011;
  localparam logic [ALUOP_W-1:0] ALUOP_MULT  = 8'b0001_1000;
  localparam logic [ALUOP_W-1:0] ALUOP_MULTU = 8'b0001_1001;
  localparam logic [ALUOP_W-1:0] ALUOP_DIV   = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] ALUOP_DIVU  = 8'b0001_1011;

  // Iterative engine states
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // Multiply/divide flavour handed to the engine
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdu_op_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_mdu_stage_if.sv
// Pipeline-facing bundle of the execute stage: ID/EX operands in, EX/MEM
// results and the stall request out.
interface ex_mdu_stage_if
  import ex_mdu_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5
);
  logic [ALUSEL_W-1:0] alusel_i;
  logic [ALUOP_W-1:0]  aluop_i;
  logic [WIDTH-1:0]    reg1_i;
  logic [WIDTH-1:0]    reg2_i;
  logic [RADDR_W-1:0]  wd_i;
  logic                wreg_i;
  logic                annul_i;
  logic [RADDR_W-1:0]  wd_o;
  logic                wreg_o;
  logic [WIDTH-1:0]    wdata_o;
  logic [WIDTH-1:0]    hi_o;
  logic [WIDTH-1:0]    lo_o;
  logic                stallreq_o;
  logic                busy_o;

  // Pipeline side: presents the instruction, consumes results
  modport master (
    output alusel_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
    input  wd_o, wreg_o, wdata_o, hi_o, lo_o, stallreq_o, busy_o
  );

  // Execute stage side
  modport slave (
    input  alusel_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
    output wd_o, wreg_o, wdata_o, hi_o, lo_o, stallreq_o, busy_o
  );
endinterface

// File: rtl/ex_mdu_stage_mdu_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per
// cycle on magnitudes, with sign correction applied while in DONE.
module mdu_iter
  import ex_mdu_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [ACC_W-1:0] cond_negate_acc(input logic [ACC_W-1:0] v, input logic neg);
    return neg ? (~v + ACC_W'(1)) : v;
  endfunction

  mdu_state_e       state_r, state_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [ACC_W-1:0] acc_r, acc_nx;
  logic [WIDTH-1:0] opb_r, opb_nx;     // multiplicand or divisor magnitude
  logic             neg_q_r, neg_q_nx; // product / quotient is negative
  logic             neg_r_r, neg_r_nx; // remainder follows the dividend sign
  logic             dz_r, dz_nx;       // divide by zero
  logic             div_r, div_nx;

  logic             a_neg, b_neg, op_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, rem_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [ACC_W-1:0] mul_step, div_step, prod;
  logic [WIDTH-1:0] quo, rem;

  // Operand magnitudes and sign bits of the op being launched
  always_comb begin
    op_div = op_is_div(op);
    a_neg  = op_is_signed(op) & a[WIDTH-1];
    b_neg  = op_is_signed(op) & b[WIDTH-1];
    mag_a  = cond_negate(a, a_neg);
    mag_b  = cond_negate(b, b_neg);
  end

  // One multiply step (add-then-shift) and one restoring divide step
  always_comb begin
    mul_sum   = {1'b0, acc_r[ACC_W-1:WIDTH]} + {1'b0, (acc_r[0] ? opb_r : WIDTH'(0))};
    mul_step  = {mul_sum, acc_r[WIDTH-1:1]};
    rem_shift = acc_r[ACC_W-1:WIDTH-1];
    div_diff  = rem_shift - {1'b0, opb_r};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    div_step  = {div_rem, acc_r[WIDTH-2:0], div_ge};
  end

  // Sign fix-up of the finished magnitudes; only consumed while done=1
  always_comb begin
    prod = cond_negate_acc(acc_r, neg_q_r);
    quo  = dz_r ? {WIDTH{1'b1}} : cond_negate(acc_r[WIDTH-1:0], neg_q_r);
    rem  = cond_negate(acc_r[ACC_W-1:WIDTH], neg_r_r);
    hi   = div_r ? rem : prod[ACC_W-1:WIDTH];
    lo   = div_r ? quo : prod[WIDTH-1:0];
    busy = (state_r != MDU_IDLE);
    done = (state_r == MDU_DONE);
  end

  // Next-state and datapath-update logic of the engine FSM
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    acc_nx   = acc_r;
    opb_nx   = opb_r;
    neg_q_nx = neg_q_r;
    neg_r_nx = neg_r_r;
    dz_nx    = dz_r;
    div_nx   = div_r;
    if (annul) begin
      state_nx = MDU_IDLE;
    end else begin
      case (state_r)
        MDU_IDLE: begin
          if (start) begin
            opb_nx   = op_div ? mag_b : mag_a;
            acc_nx   = {WIDTH'(0), (op_div ? mag_a : mag_b)};
            cnt_nx   = CNT_W'(0);
            neg_q_nx = a_neg ^ b_neg;
            neg_r_nx = a_neg;
            dz_nx    = op_div && (b == WIDTH'(0));
            div_nx   = op_div;
            state_nx = op_div ? MDU_DIV : MDU_MUL;
          end else begin
            state_nx = MDU_IDLE;
          end
        end
        MDU_MUL: begin
          acc_nx   = mul_step;
          cnt_nx   = cnt_r + CNT_W'(1);
          state_nx = (cnt_r == LAST_STEP) ? MDU_DONE : MDU_MUL;
        end
        MDU_DIV: begin
          acc_nx   = div_step;
          cnt_nx   = cnt_r + CNT_W'(1);
          state_nx = (cnt_r == LAST_STEP) ? MDU_DONE : MDU_DIV;
        end
        MDU_DONE: begin
          state_nx = MDU_IDLE;
        end
        default: begin
          state_nx = MDU_IDLE;
        end
      endcase
    end
  end

  // Engine state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MDU_IDLE;
      cnt_r   <= CNT_W'(0);
      acc_r   <= ACC_W'(0);
      opb_r   <= WIDTH'(0);
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
      div_r   <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      acc_r   <= acc_nx;
      opb_r   <= opb_nx;
      neg_q_r <= neg_q_nx;
      neg_r_r <= neg_r_nx;
      dz_r    <= dz_nx;
      div_r   <= div_nx;
    end
  end

endmodule

// File: rtl/ex_mdu_stage.sv
// MIPS execute stage: single-cycle logic/shift/arith/move datapath, HI/LO
// registers, and stall generation around the iterative multiply/divide engine.
module ex_mdu_stage
  import ex_mdu_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5
) (
  input logic           clk,
  input logic           rst,
  ex_mdu_stage_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SH_W  = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_r, lo_r;
  logic [WIDTH-1:0] result;
  logic [SH_W-1:0]  shamt;
  mdu_op_e          md_op;
  logic             md_req, is_mt, mthi_w, mtlo_w, stall;
  logic             iter_busy, iter_done;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  mdu_iter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mdu_iter (
    .clk   (clk),
    .rst   (rst),
    .start (md_req),
    .op    (md_op),
    .a     (bus.reg1_i),
    .b     (bus.reg2_i),
    .annul (bus.annul_i),
    .busy  (iter_busy),
    .done  (iter_done),
    .hi    (iter_hi),
    .lo    (iter_lo)
  );

  // Decode of MulDiv launch, HI/LO moves and the stall request
  always_comb begin
    md_op = MD_MULTU;
    case (bus.aluop_i)
      ALUOP_MULT:  md_op = MD_MULT;
      ALUOP_MULTU: md_op = MD_MULTU;
      ALUOP_DIV:   md_op = MD_DIV;
      ALUOP_DIVU:  md_op = MD_DIVU;
      default:     md_op = MD_MULTU;
    endcase
    md_req = (bus.alusel_i == ALUSEL_MULDIV) && !bus.annul_i;
    is_mt  = (bus.alusel_i == ALUSEL_MOVE) &&
             ((bus.aluop_i == ALUOP_MTHI) || (bus.aluop_i == ALUOP_MTLO));
    mthi_w = (bus.alusel_i == ALUSEL_MOVE) && (bus.aluop_i == ALUOP_MTHI) && !bus.annul_i;
    mtlo_w = (bus.alusel_i == ALUSEL_MOVE) && (bus.aluop_i == ALUOP_MTLO) && !bus.annul_i;
    // Stall in the launching IDLE cycle and every MUL/DIV cycle; DONE releases.
    stall  = (!iter_busy && md_req) || (iter_busy && !iter_done);
    shamt  = bus.reg1_i[SH_W-1:0];
  end

  // Single-cycle result selection
  always_comb begin
    result = WIDTH'(0);
    case (bus.alusel_i)
      ALUSEL_LOGIC: begin
        case (bus.aluop_i)
          ALUOP_AND, ALUOP_ANDI, ALUOP_LUI: result = bus.reg1_i & bus.reg2_i;
          ALUOP_OR, ALUOP_ORI:              result = bus.reg1_i | bus.reg2_i;
          ALUOP_NOR:                        result = ~(bus.reg1_i | bus.reg2_i);
          ALUOP_XOR, ALUOP_XORI:            result = bus.reg1_i ^ bus.reg2_i;
          default:                          result = WIDTH'(0);
        endcase
      end
      ALUSEL_SHIFT: begin
        case (bus.aluop_i)
          ALUOP_SLL: result = bus.reg2_i << shamt;
          ALUOP_SRL: result = bus.reg2_i >> shamt;
          ALUOP_SRA: result = $signed(bus.reg2_i) >>> shamt;
          default:   result = WIDTH'(0);
        endcase
      end
      ALUSEL_ARITH: begin
        case (bus.aluop_i)
          ALUOP_ADD, ALUOP_ADDU: result = bus.reg1_i + bus.reg2_i;
          ALUOP_SUB, ALUOP_SUBU: result = bus.reg1_i - bus.reg2_i;
          ALUOP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(bus.reg1_i) < $signed(bus.reg2_i))};
          ALUOP_SLTU: result = {{(WIDTH-1){1'b0}}, (bus.reg1_i < bus.reg2_i)};
          default:    result = WIDTH'(0);
        endcase
      end
      ALUSEL_MOVE: begin
        case (bus.aluop_i)
          ALUOP_MFHI: result = hi_r;
          ALUOP_MFLO: result = lo_r;
          default:    result = WIDTH'(0);
        endcase
      end
      default: result = WIDTH'(0);
    endcase
  end

  // HI/LO registers: a finishing multiply/divide takes priority over MTHI/MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= WIDTH'(0);
      lo_r <= WIDTH'(0);
    end else if (iter_done && !bus.annul_i) begin
      hi_r <= iter_hi;
      lo_r <= iter_lo;
    end else if (mthi_w) begin
      hi_r <= bus.reg1_i;
    end else if (mtlo_w) begin
      lo_r <= bus.reg1_i;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Output drive; everything reads zero while reset is held
  always_comb begin
    if (rst) begin
      bus.wd_o       = RADDR_W'(0);
      bus.wreg_o     = 1'b0;
      bus.wdata_o    = WIDTH'(0);
      bus.hi_o       = WIDTH'(0);
      bus.lo_o       = WIDTH'(0);
      bus.stallreq_o = 1'b0;
      bus.busy_o     = 1'b0;
    end else begin
      bus.wd_o       = bus.wd_i;
      bus.wreg_o     = bus.wreg_i && !stall && !is_mt && (bus.alusel_i != ALUSEL_MULDIV);
      bus.wdata_o    = result;
      bus.hi_o       = hi_r;
      bus.lo_o       = lo_r;
      bus.stallreq_o = stall;
      bus.busy_o     = iter_busy;
    end
  end

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Scoreboard bench for ex_mdu_stage: each issued instruction pushes its
// expected outcome, which is popped and compared when the instruction retires.
module tb_ex_mdu_stage;
  import ex_mdu_stage_pkg::*;

  parameter int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] wdata;
    logic             chk_wdata;
    logic             wreg;
    logic [4:0]       wd;
    logic             busy;
    int               stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  logic [WIDTH-1:0] m_hi = '0;
  logic [WIDTH-1:0] m_lo = '0;

  always #5 clk = ~clk;

  ex_mdu_stage_if #(.WIDTH(WIDTH), .RADDR_W(5)) bus ();

  ex_mdu_stage #(.WIDTH(WIDTH), .RADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference single-cycle result
  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] sel, input logic [7:0] op,
                                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int sh;
    sh = int'(a) % WIDTH;
    if (sel == ALUSEL_LOGIC) begin
      if (op == ALUOP_OR || op == ALUOP_ORI) return a | b;
      if (op == ALUOP_AND || op == ALUOP_ANDI || op == ALUOP_LUI) return a & b;
      if (op == ALUOP_NOR) return ~(a | b);
      if (op == ALUOP_XOR || op == ALUOP_XORI) return a ^ b;
    end
    if (sel == ALUSEL_SHIFT) begin
      if (op == ALUOP_SLL) return b << sh;
      if (op == ALUOP_SRL) return b >> sh;
      if (op == ALUOP_SRA) return $signed(b) >>> sh;
    end
    if (sel == ALUSEL_ARITH) begin
      if (op == ALUOP_ADD || op == ALUOP_ADDU) return a + b;
      if (op == ALUOP_SUB || op == ALUOP_SUBU) return a - b;
      if (op == ALUOP_SLT) return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
      if (op == ALUOP_SLTU) return (a < b) ? WIDTH'(1) : WIDTH'(0);
    end
    if (sel == ALUSEL_MOVE) begin
      if (op == ALUOP_MFHI) return m_hi;
      if (op == ALUOP_MFLO) return m_lo;
    end
    return '0;
  endfunction

  // Reference multiply/divide using 64-bit native arithmetic
  task automatic ref_muldiv(input logic [7:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            output logic [WIDTH-1:0] hi, output logic [WIDTH-1:0] lo);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    hi = '0;
    lo = '0;
    if (op == ALUOP_MULT) begin
      p = sa * sb;
      {hi, lo} = p[2*WIDTH-1:0];
    end else if (op == ALUOP_MULTU) begin
      p = ua * ub;
      {hi, lo} = p[2*WIDTH-1:0];
    end else if (b == '0) begin
      lo = '1;
      hi = a;
    end else if (op == ALUOP_DIV) begin
      sq = sa / sb;
      sr = sa % sb;
      lo = sq[WIDTH-1:0];
      hi = sr[WIDTH-1:0];
    end else begin
      p  = ua / ub;
      lo = p[WIDTH-1:0];
      p  = ua % ub;
      hi = p[WIDTH-1:0];
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [4:0] wd, input logic wreg);
    bus.alusel_i = sel;
    bus.aluop_i  = op;
    bus.reg1_i   = a;
    bus.reg2_i   = b;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
    bus.annul_i  = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [2:0] sel, input logic [7:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [4:0] wd, input logic wreg);
    exp_t e, g;
    int   n;
    logic first_stall;
    e.wd = wd;
    if (sel == ALUSEL_MULDIV) begin
      ref_muldiv(op, a, b, m_hi, m_lo);
      e.wdata = '0; e.chk_wdata = 1'b0; e.wreg = 1'b0; e.busy = 1'b1; e.stall = WIDTH + 1;
    end else begin
      e.wdata = ref_alu(sel, op, a, b); e.chk_wdata = 1'b1; e.busy = 1'b0; e.stall = 0;
      e.wreg = wreg && !(sel == ALUSEL_MOVE && (op == ALUOP_MTHI || op == ALUOP_MTLO));
      if (sel == ALUSEL_MOVE && op == ALUOP_MTHI) m_hi = a;
      if (sel == ALUSEL_MOVE && op == ALUOP_MTLO) m_lo = a;
    end
    e.hi = m_hi;
    e.lo = m_lo;
    exp_q.push_back(e);
    drive(sel, op, a, b, wd, wreg);
    @(negedge clk);
    first_stall = bus.stallreq_o;
    n = 0;
    while (bus.stallreq_o && n < 4 * WIDTH) begin
      n++;
      @(negedge clk);
    end
    g = exp_q.pop_front();
    check_val($sformatf("%s.first_stall", tag), first_stall, g.busy);
    check_val($sformatf("%s.stall_cycles", tag), n, g.stall);
    check_val($sformatf("%s.wreg", tag), bus.wreg_o, g.wreg);
    check_val($sformatf("%s.wd", tag), bus.wd_o, g.wd);
    check_val($sformatf("%s.busy", tag), bus.busy_o, g.busy);
    if (g.chk_wdata) check_val($sformatf("%s.wdata", tag), bus.wdata_o, g.wdata);
    @(posedge clk);
    #1;
    check_val($sformatf("%s.hi", tag), bus.hi_o, g.hi);
    check_val($sformatf("%s.lo", tag), bus.lo_o, g.lo);
  endtask

  task automatic check_all_zero(input string tag);
    check_val($sformatf("%s.wd", tag), bus.wd_o, 0);
    check_val($sformatf("%s.wreg", tag), bus.wreg_o, 0);
    check_val($sformatf("%s.wdata", tag), bus.wdata_o, 0);
    check_val($sformatf("%s.hi", tag), bus.hi_o, 0);
    check_val($sformatf("%s.lo", tag), bus.lo_o, 0);
    check_val($sformatf("%s.stall", tag), bus.stallreq_o, 0);
    check_val($sformatf("%s.busy", tag), bus.busy_o, 0);
  endtask

  logic [WIDTH-1:0] min_neg, all_one, ra, rb;
  logic [7:0]       md_ops [4];

  initial begin
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    all_one = '1;
    md_ops[0] = ALUOP_MULT; md_ops[1] = ALUOP_MULTU; md_ops[2] = ALUOP_DIV; md_ops[3] = ALUOP_DIVU;

    // Reset with a live instruction on the inputs: every output must read 0
    drive(ALUSEL_LOGIC, ALUOP_OR, WIDTH'(32'hF0), WIDTH'(32'h0F), 5'd5, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single-cycle classes
    issue("ori",   ALUSEL_LOGIC, ALUOP_ORI,  WIDTH'(32'hF0), WIDTH'(32'h0F), 5'd3, 1'b1);
    issue("sra",   ALUSEL_SHIFT, ALUOP_SRA,  WIDTH'(4), min_neg, 5'd4, 1'b1);
    issue("and",   ALUSEL_LOGIC, ALUOP_AND,  WIDTH'(32'hF0F0), WIDTH'(32'h0FF0), 5'd6, 1'b1);
    issue("nor",   ALUSEL_LOGIC, ALUOP_NOR,  WIDTH'(32'h00F0), WIDTH'(32'h000F), 5'd7, 1'b1);
    issue("xor",   ALUSEL_LOGIC, ALUOP_XOR,  WIDTH'(32'hA5A5), WIDTH'(32'hFFFF), 5'd8, 1'b1);
    issue("sll",   ALUSEL_SHIFT, ALUOP_SLL,  WIDTH'(WIDTH + 3), WIDTH'(32'h1), 5'd9, 1'b1);
    issue("srl",   ALUSEL_SHIFT, ALUOP_SRL,  WIDTH'(WIDTH - 1), min_neg, 5'd10, 1'b1);
    issue("addu",  ALUSEL_ARITH, ALUOP_ADDU, all_one, WIDTH'(1), 5'd11, 1'b1);
    issue("sub",   ALUSEL_ARITH, ALUOP_SUB,  WIDTH'(3), WIDTH'(5), 5'd12, 1'b1);
    issue("slt",   ALUSEL_ARITH, ALUOP_SLT,  all_one, WIDTH'(1), 5'd13, 1'b1);
    issue("sltu",  ALUSEL_ARITH, ALUOP_SLTU, all_one, WIDTH'(1), 5'd14, 1'b0);
    issue("mthi",  ALUSEL_MOVE,  ALUOP_MTHI, WIDTH'(32'h1234), '0, 5'd15, 1'b1);

    // Flush of a MULTU in flight: HI/LO untouched, FSM back to IDLE
    drive(ALUSEL_MULDIV, ALUOP_MULTU, WIDTH'(5), WIDTH'(5), 5'd1, 1'b1);
    repeat (10) @(negedge clk);
    check_val("annul.pre_stall", bus.stallreq_o, 1);
    @(posedge clk);
    #1 bus.annul_i = 1'b1;
    @(posedge clk);
    #1 drive(ALUSEL_NOP, ALUOP_OR, '0, '0, 5'd0, 1'b0);
    @(negedge clk);
    check_val("annul.busy", bus.busy_o, 0);
    check_val("annul.stall", bus.stallreq_o, 0);
    check_val("annul.hi", bus.hi_o, m_hi);
    check_val("annul.lo", bus.lo_o, m_lo);
    @(posedge clk);
    #1;

    // Multiply/divide and follow-up moves; MULT and DIV back to back
    issue("mult",    ALUSEL_MULDIV, ALUOP_MULT, WIDTH'(-3), WIDTH'(7), 5'd2, 1'b1);
    issue("mflo",    ALUSEL_MOVE,   ALUOP_MFLO, '0, '0, 5'd2, 1'b1);
    issue("mfhi",    ALUSEL_MOVE,   ALUOP_MFHI, '0, '0, 5'd3, 1'b1);
    issue("mult_b2b", ALUSEL_MULDIV, ALUOP_MULT, WIDTH'(-100), WIDTH'(-200), 5'd2, 1'b0);
    issue("div",     ALUSEL_MULDIV, ALUOP_DIV,  WIDTH'(-7), WIDTH'(2), 5'd2, 1'b1);
    issue("divu_z",  ALUSEL_MULDIV, ALUOP_DIVU, WIDTH'(7), '0, 5'd2, 1'b1);
    issue("div_z",   ALUSEL_MULDIV, ALUOP_DIV,  WIDTH'(-5), '0, 5'd2, 1'b1);
    issue("div_ovf", ALUSEL_MULDIV, ALUOP_DIV,  min_neg, all_one, 5'd2, 1'b1);
    issue("div_nb",  ALUSEL_MULDIV, ALUOP_DIV,  WIDTH'(7), WIDTH'(-2), 5'd2, 1'b1);
    issue("mtlo",    ALUSEL_MOVE,   ALUOP_MTLO, WIDTH'(32'h55AA), '0, 5'd4, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ra = WIDTH'($urandom);
      rb = (i == 2) ? WIDTH'($urandom_range(1, 9)) : WIDTH'($urandom);
      issue($sformatf("rand%0d", i), ALUSEL_MULDIV, md_ops[i % 4], ra, rb, 5'd1, 1'b1);
    end

    // Reset in the middle of a divide aborts it and clears HI/LO
    drive(ALUSEL_MULDIV, ALUOP_DIV, WIDTH'(100), WIDTH'(7), 5'd9, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    drive(ALUSEL_NOP, ALUOP_OR, '0, '0, 5'd0, 1'b0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    check_val("rst_mid.after_busy", bus.busy_o, 0);
    check_val("rst_mid.after_hi", bus.hi_o, 0);
    check_val("rst_mid.after_lo", bus.lo_o, 0);
    @(posedge clk);
    #1;
    issue("multu_max", ALUSEL_MULDIV, ALUOP_MULTU, all_one, WIDTH'(2), 5'd1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mdu_stage.md
# ex_mdu_stage

Parametrised execute stage for the MIPS pipeline. It keeps single-cycle evaluation of logic, shift and arithmetic ops, and adds architectural HI/LO registers plus an iterative multiply/divide unit. The unit stalls the pipeline through a `stallreq_o` handshake. It sits between the ID/EX and EX/MEM pipeline registers and replaces the logic-only execute stage.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; must be even and at least 8.
- `RADDR_W`, 5: register-file address width.
- `CNT_W`, `$clog2(WIDTH+1)`: iteration-counter width; derived, not overridden.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `alusel_i` in 3: op class: Logic, Shift, Arith, Move, MulDiv.
- `aluop_i` in 8: operation code within the class.
- `reg1_i` in WIDTH: operand A (rs).
- `reg2_i` in WIDTH: operand B (rt or immediate).
- `wd_i` in RADDR_W: destination register.
- `wreg_i` in 1: destination write enable.
- `annul_i` in 1: flush of the instruction currently in EX.
- `wd_o` out RADDR_W: pass-through of `wd_i`.
- `wreg_o` out 1: `wreg_i`, forced to 0 while `stallreq_o=1`.
- `wdata_o` out WIDTH: result.
- `hi_o` out WIDTH: current HI.
- `lo_o` out WIDTH: current LO.
- `stallreq_o` out 1: requests that IF/ID/EX hold.
- `busy_o` out 1: FSM is not in IDLE.

## Operation
- **Logic class:** AND/ANDI/LUI give A&B; OR/ORI give A|B; NOR gives ~(A|B); XOR/XORI give A^B.
- **Shift class:** SLL/SRL/SRA shift B by A[$clog2(WIDTH)-1:0].
- **Arith class:**
  - ADD/ADDU/SUB/SUBU compute modulo 2^WIDTH.
  - SLT compares signed; SLTU compares unsigned.
  - No overflow trap.
- **Move class:**
  - MFHI and MFLO put HI or LO on `wdata_o`.
  - MTHI and MTLO write A into HI or LO at the end of the cycle; `wreg_o` is 0 for these.
- **MulDiv class:** MULT, MULTU, DIV, DIVU. `wreg_o` is 0 for all four. Results go to HI and LO only.
- **FSM states:** IDLE, MUL, DIV, DONE.
  - **IDLE:**
    - With a MulDiv op, `annul_i=0`: latch |A| and |B| (raw values for unsigned ops) and the result sign bits; clear the counter; go to MUL or DIV.
    - With any other op: stay in IDLE.
  - **MUL:** one shift-add step per cycle on a 2·WIDTH accumulator. After WIDTH steps, go to DONE.
  - **DIV:** one restoring step per cycle. After WIDTH steps, go to DONE.
  - **DONE:** apply sign correction and write HI/LO on the clock edge that leaves DONE; go to IDLE.
- **Results:**
  - Multiply: {HI,LO} = product.
  - Divide: LO = quotient, HI = remainder. The quotient truncates toward zero; the remainder takes the dividend's sign.
- **Divide by zero:** takes the same iterations and gives LO = all ones, HI = dividend. No exception.
- **Signed overflow** (DIV of most-negative by -1): LO = most-negative, HI = 0.
- **Annul:** `annul_i=1` in any state returns the FSM to IDLE on the next edge. HI/LO are not modified.
- **Write priority:** a DONE write and an MTHI/MTLO cannot coincide, because the instruction is held while the FSM is busy. If both ever occur, the DONE write wins.

## Timing
- **Reset** (on the edge with `rst=1`):
  - FSM goes to IDLE; counter and accumulator clear; HI = LO = 0.
  - While `rst=1`, all outputs are 0: `wd_o`, `wreg_o`, `wdata_o`, `hi_o`, `lo_o`, `stallreq_o`, `busy_o`.
  - A reset mid-operation aborts it.
- **Combinational path:** non-MulDiv results are combinational from the inputs; EX adds no latency.
- **`stallreq_o`:**
  - Asserts combinationally in the IDLE cycle that presents a MulDiv op (unless `annul_i=1`).
  - Stays high through all MUL/DIV cycles.
  - Is 0 in DONE.
  - The total stall is WIDTH+1 cycles. HI/LO are valid in the cycle after DONE, so MFHI/MFLO issued right after see the new values.
- **Held instruction:** the pipeline keeps the same MulDiv op on the inputs while stalled. The FSM ignores inputs outside IDLE, except `annul_i`.
- **Back-to-back MulDiv:** in the cycle after DONE the FSM is in IDLE and the next op starts immediately.
- **Outputs:** `hi_o` and `lo_o` are registered.

## Structure
- **Shared package (`defines.v`):** holds these values; no literals in the RTL:
  - alusel encodings;
  - aluop encodings, including MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU, SLL, SRL, SRA, ADD, ADDU, SUB, SUBU, SLT, SLTU;
  - FSM state encodings.
- **Sub-module `mdu_iter`:** the iterative engine, containing the FSM, counter, accumulator and sign fix-up.
  - Inputs: `start`, `op`, `a`, `b`, `annul`.
  - Outputs: `busy`, `done`, `hi`, `lo`.
- **`ex_mdu_stage` itself:** single-cycle datapath, HI/LO registers, stall generation.

## Test plan
- **Logic and shift:** ORI with A=0x0000_00F0, B=0x0000_000F gives `wdata_o`=0x0000_00FF, `wreg_o`=1. SRA with B=0x8000_0000, A=4 gives 0xF800_0000.
- **Signed multiply:** MULT A=-3, B=7 gives `stallreq_o` high for 33 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. A following MFLO returns 0xFFFF_FFEB.
- **Signed divide:** DIV A=-7, B=2 gives LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU A=7, B=0 gives LO=0xFFFF_FFFF, HI=7.
- **Flush mid-operation:** MTHI A=0x1234 first. Then issue MULTU 5×5 and assert `annul_i` after 10 cycles. The FSM reaches IDLE next cycle, `stallreq_o` drops, HI=0x1234 and LO=0 are unchanged.
- **Reset mid-operation:** pulse `rst` during DIV. All outputs read 0, and the next MULTU 0xFFFF_FFFF×2 gives HI=1, LO=0xFFFF_FFFE.
- **Back-to-back and width parameter:** MULT immediately followed by DIV; the second op starts in the cycle after DONE. Rerun the suite with WIDTH=16, where stalls are 17 cycles.
